// File: rtl/lite16_pkg.sv
// Shared LITE-16 fetch types and constants.
// Used by the fetch unit and its prefetch FIFO.
package lite16_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] LITE16_RESET_PC = 16'h0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

    // Sequential fetch address; natural 16-bit wrap at the top of memory.
    function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
        return pc + 16'h0001;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} pairs with synchronous flush.
// The head entry is presented straight from its register.
module fetch_fifo
    import lite16_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;

    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == {CNT_W{1'b0}});
    assign head  = mem_r[rd_ptr_r];

    // Entry storage; flush leaves contents alone since count hides them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '{pc: 16'h0000, instr: 16'h0000};
            end
        end else if (push && !flush) begin
            mem_r[wr_ptr_r] <= wr_entry;
        end else begin
            mem_r <= mem_r;
        end
    end

    // Pointers and occupancy; flush wins over any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// LITE-16 instruction fetch stage: owns the fetch PC, drives the ROM
// address and feeds decode through the prefetch FIFO.
module fetch_unit
    import lite16_pkg::*;
#(
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = LITE16_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] rom_address,
    input  logic [15:0] rom_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_data,
    output logic [15:0] instr_pc
);

    logic [ADDR_W-1:0] fetch_pc_r;
    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    fetch_entry_t      head_s;
    fetch_entry_t      wr_entry_s;

    // A redirect suppresses both sides so the stale head is dropped, not consumed.
    assign pop_s      = ~empty_s & instr_ready & ~redirect_valid;
    assign push_s     = ~redirect_valid & ~halt & (~full_s | pop_s);
    assign wr_entry_s = '{pc: fetch_pc_r, instr: rom_data};

    assign rom_address = fetch_pc_r;
    assign instr_valid = ~empty_s;
    assign instr_data  = head_s.instr;
    assign instr_pc    = head_s.pc;

    // Fetch PC: redirect first, then advance on every accepted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc_r <= redirect_pc;
        end else if (push_s) begin
            fetch_pc_r <= pc_incr(fetch_pc_r);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_s),
        .pop      (pop_s),
        .flush    (redirect_valid),
        .wr_entry (wr_entry_s),
        .full     (full_s),
        .empty    (empty_s),
        .head     (head_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit against a ROM holding 16'hA000+addr.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rom_address;
    logic [15:0] rom_data;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [15:0] rpc;
        logic        hlt;
        logic        ev;
        logic [15:0] epc;
        logic [15:0] edata;
        logic [15:0] eaddr;
    } vec_t;

    vec_t vecs [19];

    always #5 clk = ~clk;

    // Full 64K-word ROM model
    assign rom_data = 16'hA000 + rom_address;

    fetch_unit #(.FIFO_DEPTH(2), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_address    (rom_address),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Each row checks the state present now, then applies its inputs for the next edge.
    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            check($sformatf("row%0d valid", i), {15'd0, instr_valid}, {15'd0, vecs[i].ev});
            check($sformatf("row%0d addr", i), rom_address, vecs[i].eaddr);
            if (vecs[i].ev) begin
                check($sformatf("row%0d pc", i), instr_pc, vecs[i].epc);
                check($sformatf("row%0d data", i), instr_data, vecs[i].edata);
            end
            instr_ready    = vecs[i].rdy;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            halt           = vecs[i].hlt;
            @(negedge clk);
        end
    endtask

    initial begin
        //           rdy   redir  rpc       halt  ev    epc       edata     eaddr
        vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'hA000, 16'h0001};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'hA001, 16'h0002};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'hA002, 16'h0003};
        vecs[4]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'hA002, 16'h0004};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'hA002, 16'h0004};
        vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0003, 16'hA003, 16'h0005};
        vecs[7]  = '{1'b1, 1'b1, 16'h0040, 1'b0, 1'b1, 16'h0004, 16'hA004, 16'h0006};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0040};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'hA040, 16'h0041};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'hA040, 16'h0042};
        vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0041, 16'hA041, 16'h0042};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0042};
        vecs[13] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0042};
        vecs[14] = '{1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 16'h0042, 16'hA042, 16'h0043};
        vecs[15] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[16] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'h9FFF, 16'h0000};
        vecs[17] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'hA000, 16'h0001};
        vecs[18] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 16'hA001, 16'h0002};

        // Reset values while rst_n is held low across edges
        repeat (2) @(negedge clk);
        check("rst valid", {15'd0, instr_valid}, 16'h0000);
        check("rst addr", rom_address, 16'h0000);
        check("rst pc", instr_pc, 16'h0000);
        check("rst data", instr_data, 16'h0000);
        rst_n = 1'b1;

        run_rows(0, 18);

        // Asynchronous reset between edges with a non-empty FIFO
        check("pre-rst valid", {15'd0, instr_valid}, 16'h0001);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst valid", {15'd0, instr_valid}, 16'h0000);
        check("async rst addr", rom_address, 16'h0000);
        check("async rst pc", instr_pc, 16'h0000);
        check("async rst data", instr_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_rows(0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
